// File: rtl/aurora_tx_pkg.sv
// Shared constants and types for the Aurora 64b/66b transmit block source.
package aurora_tx_pkg;

  localparam logic [1:0]  SYNC_DATA  = 2'b01;
  localparam logic [1:0]  SYNC_CTRL  = 2'b10;
  localparam logic [7:0]  BTF_IDLE   = 8'h78;
  localparam logic [63:0] IDLE_BLOCK = {BTF_IDLE, 56'h0};
  localparam logic [63:0] CC_BLOCK   = 64'h7880_0000_0000_0000;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StCc
  } tx_state_e;

endpackage

// File: rtl/aurora_tx_fifo.sv
// Synchronous 64-bit user-word FIFO; head word is read from registered storage (no fall-through).
module aurora_tx_fifo
  import aurora_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk40,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk40) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk40) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/aurora_tx_block_gen.sv
// Aurora TX block source: init idles, user data from a FIFO, idle fill and periodic CC bursts.
module aurora_tx_block_gen
  import aurora_tx_pkg::*;
#(
  parameter int unsigned INIT_IDLES = 64,
  parameter int unsigned CC_PERIOD  = 5000,
  parameter int unsigned CC_LEN     = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk40,
  input  logic        rst,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        enable,
  output logic [63:0] data_out,
  output logic [1:0]  sync_out,
  output logic        channel_up,
  output logic        cc_active,
  output logic [31:0] blocks_sent
);

  localparam int unsigned InitW  = $clog2(INIT_IDLES + 1);
  localparam int unsigned CcW    = $clog2(CC_PERIOD);
  localparam int unsigned BurstW = $clog2(CC_LEN + 1);

  tx_state_e         state_q, state_d;
  logic [InitW-1:0]  init_cnt_q, init_cnt_d;
  logic [CcW-1:0]    cc_cnt_q, cc_cnt_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [63:0]       data_q, data_d;
  logic [1:0]        sync_q, sync_d;
  logic              cc_active_q, cc_active_d;
  logic              channel_up_q, channel_up_d;
  logic [31:0]       blocks_sent_q, blocks_sent_d;

  logic        fifo_full, fifo_empty, fifo_pop;
  logic [63:0] fifo_dout;

  // Registered-state only: no combinational path from s_valid.
  assign s_ready = channel_up_q & ~fifo_full;

  aurora_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk40 (clk40),
    .rst   (rst),
    .push  (s_valid & s_ready),
    .pop   (fifo_pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    cc_cnt_d      = cc_cnt_q;
    burst_d       = burst_q;
    data_d        = data_q;
    sync_d        = sync_q;
    cc_active_d   = cc_active_q;
    channel_up_d  = channel_up_q;
    blocks_sent_d = blocks_sent_q;
    fifo_pop      = 1'b0;
    if (enable) begin
      blocks_sent_d = blocks_sent_q + 32'd1;
      unique case (state_q)
        StInit: begin
          data_d      = IDLE_BLOCK;
          sync_d      = SYNC_CTRL;
          cc_active_d = 1'b0;
          if (init_cnt_q == InitW'(INIT_IDLES - 1)) begin
            state_d      = StRun;
            channel_up_d = 1'b1;
            init_cnt_d   = '0;
          end else begin
            init_cnt_d = init_cnt_q + InitW'(1);
          end
        end
        StRun: begin
          if (cc_cnt_q == CcW'(CC_PERIOD - 1)) begin
            data_d      = CC_BLOCK;
            sync_d      = SYNC_CTRL;
            cc_active_d = 1'b1;
            cc_cnt_d    = '0;
            burst_d     = BurstW'(1);
            // A one-block burst is already complete.
            state_d     = (CC_LEN > 1) ? StCc : StRun;
          end else begin
            cc_cnt_d    = cc_cnt_q + CcW'(1);
            cc_active_d = 1'b0;
            if (!fifo_empty) begin
              data_d   = fifo_dout;
              sync_d   = SYNC_DATA;
              fifo_pop = 1'b1;
            end else begin
              data_d = IDLE_BLOCK;
              sync_d = SYNC_CTRL;
            end
          end
        end
        StCc: begin
          data_d      = CC_BLOCK;
          sync_d      = SYNC_CTRL;
          cc_active_d = 1'b1;
          if (burst_q == BurstW'(CC_LEN - 1)) begin
            state_d = StRun;
            burst_d = '0;
          end else begin
            burst_d = burst_q + BurstW'(1);
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk40) begin
    if (rst) begin
      state_q       <= StInit;
      init_cnt_q    <= '0;
      cc_cnt_q      <= '0;
      burst_q       <= '0;
      data_q        <= '0;
      sync_q        <= 2'b00;
      cc_active_q   <= 1'b0;
      channel_up_q  <= 1'b0;
      blocks_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      cc_cnt_q      <= cc_cnt_d;
      burst_q       <= burst_d;
      data_q        <= data_d;
      sync_q        <= sync_d;
      cc_active_q   <= cc_active_d;
      channel_up_q  <= channel_up_d;
      blocks_sent_q <= blocks_sent_d;
    end
  end

  assign data_out    = data_q;
  assign sync_out    = sync_q;
  assign cc_active   = cc_active_q;
  assign channel_up  = channel_up_q;
  assign blocks_sent = blocks_sent_q;

endmodule

// File: tb/tb_aurora_tx_block_gen.sv
// Directed + random bench for aurora_tx_block_gen against a block-index reference model.
module tb_aurora_tx_block_gen;

  localparam int unsigned INIT  = 4;
  localparam int unsigned PER   = 8;
  localparam int unsigned CLEN  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CYC   = PER - 1 + CLEN;

  localparam logic [63:0] IDLE_W = 64'h7800_0000_0000_0000;
  localparam logic [63:0] CC_W   = 64'h7880_0000_0000_0000;

  logic        clk40 = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        enable;
  logic [63:0] data_out;
  logic [1:0]  sync_out;
  logic        channel_up;
  logic        cc_active;
  logic [31:0] blocks_sent;

  always #5 clk40 = ~clk40;

  aurora_tx_block_gen #(
    .INIT_IDLES (INIT),
    .CC_PERIOD  (PER),
    .CC_LEN     (CLEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk40       (clk40),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .enable      (enable),
    .data_out    (data_out),
    .sync_out    (sync_out),
    .channel_up  (channel_up),
    .cc_active   (cc_active),
    .blocks_sent (blocks_sent)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: block type is a pure function of the block index since reset.
  logic [63:0] q[$];
  int unsigned n;
  logic [63:0] exp_data;
  logic [1:0]  exp_sync;
  logic        exp_cc;
  logic [31:0] exp_bs;

  function automatic int kind(input int unsigned idx);
    if (idx < INIT) return 0;
    if (((idx - INIT) % CYC) >= PER - 1) return 2;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (block %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_outputs();
    chk("data_out", data_out, exp_data);
    chk("sync_out", 64'(sync_out), 64'(exp_sync));
    chk("cc_active", 64'(cc_active), 64'(exp_cc));
    chk("channel_up", 64'(channel_up), 64'(n >= INIT));
    chk("blocks_sent", 64'(blocks_sent), 64'(exp_bs));
  endtask

  task automatic step(input logic en, input logic vld, input logic [63:0] d);
    logic rdy;
    rst     = 1'b0;
    enable  = en;
    s_valid = vld;
    s_data  = d;
    #1;
    rdy = (n >= INIT) && (q.size() < DEPTH);
    chk("s_ready", 64'(s_ready), 64'(rdy));
    if (en) begin
      case (kind(n))
        0: begin exp_data = IDLE_W; exp_sync = 2'b10; exp_cc = 1'b0; end
        2: begin exp_data = CC_W;   exp_sync = 2'b10; exp_cc = 1'b1; end
        default: begin
          exp_cc = 1'b0;
          if (q.size() > 0) begin
            exp_data = q.pop_front();
            exp_sync = 2'b01;
          end else begin
            exp_data = IDLE_W;
            exp_sync = 2'b10;
          end
        end
      endcase
      n++;
      exp_bs++;
    end
    if (vld && rdy) q.push_back(d);
    @(posedge clk40);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = {$urandom, $urandom};
    @(posedge clk40);
    #1;
    rst      = 1'b0;
    enable   = 1'b0;
    s_valid  = 1'b0;
    q.delete();
    n        = 0;
    exp_data = '0;
    exp_sync = 2'b00;
    exp_cc   = 1'b0;
    exp_bs   = '0;
    check_outputs();
    chk("s_ready_reset", 64'(s_ready), 64'(0));
  endtask

  task automatic timeout(input string tag);
    errors++;
    $error("FAIL %s: observed timeout expected condition reached", tag);
  endtask

  initial begin
    int guard;
    rst     = 1'b1;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    do_reset();

    // Idle-only stream: 4 init idles then 7 idle / 2 CC repeating.
    repeat (20) step(1'b1, 1'b0, 64'h0);
    chk("blocks_sent_20", 64'(blocks_sent), 64'd20);

    // Three words in order, starting at a RUN slot.
    guard = 0;
    while (kind(n) != 1 && guard < 50) begin step(1'b1, 1'b0, 64'h0); guard++; end
    if (guard >= 50) timeout("reach_run");
    step(1'b1, 1'b1, 64'h1);
    step(1'b1, 1'b1, 64'h2);
    step(1'b1, 1'b1, 64'h3);
    repeat (4) step(1'b1, 1'b0, 64'h0);

    // Fill with enable low: fifth word refused, then drain.
    repeat (5) step(1'b0, 1'b1, {$urandom, $urandom});
    repeat (10) step(1'b1, 1'b0, 64'h0);

    // Word pending exactly when a CC burst is due.
    guard = 0;
    while (!(kind(n) == 2 && ((n - INIT) % CYC) == PER - 1) && guard < 50) begin
      step(1'b1, 1'b0, 64'h0);
      guard++;
    end
    if (guard >= 50) timeout("reach_cc");
    step(1'b0, 1'b1, 64'hA5A5_5A5A_0123_4567);
    step(1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
    repeat (5) step(1'b1, 1'b0, 64'h0);

    // Sparse enables with random traffic.
    for (int i = 0; i < 400; i++) begin
      step((i % 4) == 0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
    end
    repeat (20) step(1'b1, 1'b0, 64'h0);

    // Reset while in a CC burst with two words queued.
    guard = 0;
    while (!(q.size() == 0 && n > INIT && ((n - 1 - INIT) % CYC) == PER - 1) && guard < 60) begin
      step(1'b1, 1'b0, 64'h0);
      guard++;
    end
    if (guard >= 60) timeout("reach_cc_reset");
    step(1'b0, 1'b1, 64'h1111_2222_3333_4444);
    step(1'b0, 1'b1, 64'h5555_6666_7777_8888);
    do_reset();
    repeat (12) step(1'b1, 1'b0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
